// File: rtl/pixel_sreg_serializer_pkg.sv
// Shared types and sizing helpers for the pixel readout serializer.
package sreg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int PIXEL_W_DEF = 42;
  localparam int N_CHAIN_DEF = 2;

  // Bits carried by each parallel chain.
  function automatic int chain_w(input int pixel_w, input int n_chain);
    return pixel_w / n_chain;
  endfunction

  // Bit counter width; a single-bit chain still needs a 1-bit counter.
  function automatic int cnt_w(input int chain_bits);
    return (chain_bits > 1) ? $clog2(chain_bits) : 1;
  endfunction

endpackage

// File: rtl/pixel_sreg_serializer_if.sv
// Pixel-word handshake and serial-lane bundle between the pixel buffer,
// the serializer and the serial link drivers.
interface pixel_sreg_serializer_if
  import sreg_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEF,
  parameter int N_CHAIN = N_CHAIN_DEF
) ();

  logic               pixel_valid;
  logic               pixel_ready;
  logic [PIXEL_W-1:0] pixel_in;
  logic               shift_en;
  logic [N_CHAIN-1:0] sdata_out;
  logic               sdata_valid;
  logic               word_done;
  logic               busy;

  // Producer / link side: drives words and the shift enable.
  modport master (
    output pixel_valid, pixel_in, shift_en,
    input  pixel_ready, sdata_out, sdata_valid, word_done, busy
  );

  // Serializer side.
  modport slave (
    input  pixel_valid, pixel_in, shift_en,
    output pixel_ready, sdata_out, sdata_valid, word_done, busy
  );

endinterface

// File: rtl/pixel_sreg_serializer_chain.sv
// One independent shift chain: parallel load, shift toward the output end,
// zero fill at the vacated end.
module sreg_chain #(
  parameter int CHAIN_W   = 21,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic               sclk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               shift,
  input  logic [CHAIN_W-1:0] din,
  output logic               out_bit
);

  logic [CHAIN_W-1:0] sreg;

  // Load has priority so a back-to-back word replaces the drained one.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this is a handful of flops, not a memory array, so clearing
      // it in reset is cheap and keeps a stale partial word from escaping.
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= LSB_FIRST ? (sreg >> 1) : (sreg << 1);
    end
  end

  generate
    if (LSB_FIRST) begin : g_lsb
      assign out_bit = sreg[0];
    end else begin : g_msb
      assign out_bit = sreg[CHAIN_W-1];
    end
  endgenerate

endmodule

// File: rtl/pixel_sreg_serializer.sv
// Multi-chain pixel readout serializer: accepts a pixel word over a
// valid/ready handshake and shifts N_CHAIN slices out in parallel.
module pixel_sreg_serializer
  import sreg_pkg::*;
#(
  parameter int PIXEL_W   = PIXEL_W_DEF,
  parameter int N_CHAIN   = N_CHAIN_DEF,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                    sclk,
  input  logic                    rst_n,
  pixel_sreg_serializer_if.slave  bus
);

  localparam int CHAIN_W = chain_w(PIXEL_W, N_CHAIN);
  localparam int CNT_W   = cnt_w(CHAIN_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_W - 1);

  generate
    if (PIXEL_W % N_CHAIN != 0) begin : g_bad_width
      $error("pixel_sreg_serializer: PIXEL_W must be divisible by N_CHAIN");
    end
  endgenerate

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [N_CHAIN-1:0] chain_bits;
  logic               do_shift;
  logic               last_shift;
  logic               accept;

  // A new word is taken when idle, or on the final shift of the current
  // word so consecutive words stream without a bubble.
  assign do_shift        = (state == SHIFT) && bus.shift_en;
  assign last_shift      = do_shift && (cnt == LAST_CNT);
  assign bus.pixel_ready = (state == IDLE) || last_shift;
  assign accept          = bus.pixel_valid && bus.pixel_ready;
  assign bus.busy        = (state == SHIFT);

  generate
    for (genvar k = 0; k < N_CHAIN; k++) begin : g_chain
      sreg_chain #(
        .CHAIN_W   (CHAIN_W),
        .LSB_FIRST (LSB_FIRST)
      ) u_chain (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .load    (accept),
        .shift   (do_shift),
        .din     (bus.pixel_in[k*CHAIN_W +: CHAIN_W]),
        .out_bit (chain_bits[k])
      );
    end
  endgenerate

  // Framing FSM: bit counter, registered lane outputs and word_done pulse.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.sdata_out   <= '0;
      bus.sdata_valid <= 1'b0;
      bus.word_done   <= 1'b0;
    end else begin
      bus.sdata_valid <= 1'b0;
      bus.word_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (bus.shift_en) begin
            bus.sdata_out   <= chain_bits;
            bus.sdata_valid <= 1'b1;
            if (cnt == LAST_CNT) begin
              bus.word_done <= 1'b1;
              cnt           <= '0;
              if (!bus.pixel_valid) begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_sreg_serializer.sv
// Scoreboard bench: two serializers (LSB-first and MSB-first) share one
// stimulus stream; a reference model predicts every serial beat.
module tb_pixel_sreg_serializer;

  localparam int PW = 42;
  localparam int NC = 2;
  localparam int CW = PW / NC;

  typedef struct packed {
    logic [NC-1:0] data;
    logic          done;
  } beat_t;

  logic sclk;
  logic rst_n;

  logic          pv;
  logic [PW-1:0] pin;
  logic          sen;

  int total = 0;
  int bad   = 0;

  beat_t q_l[$];
  beat_t q_m[$];
  beat_t e_l, e_m;
  logic [NC-1:0] last_l, last_m;
  int  rem;
  int  valid_cnt;
  bit  mon_en;
  logic [63:0] r;

  pixel_sreg_serializer_if #(.PIXEL_W(PW), .N_CHAIN(NC)) bus_l ();
  pixel_sreg_serializer_if #(.PIXEL_W(PW), .N_CHAIN(NC)) bus_m ();

  assign bus_l.pixel_valid = pv;
  assign bus_l.pixel_in    = pin;
  assign bus_l.shift_en    = sen;
  assign bus_m.pixel_valid = pv;
  assign bus_m.pixel_in    = pin;
  assign bus_m.shift_en    = sen;

  pixel_sreg_serializer #(.PIXEL_W(PW), .N_CHAIN(NC), .LSB_FIRST(1'b1)) dut_l (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus_l)
  );

  pixel_sreg_serializer #(.PIXEL_W(PW), .N_CHAIN(NC), .LSB_FIRST(1'b0)) dut_m (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus_m)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: chain k is pixel slice k; beat j of an LSB-first lane is
  // slice bit j, of an MSB-first lane slice bit CW-1-j.
  function automatic void push_word(input logic [PW-1:0] w);
    beat_t bl, bm;
    for (int j = 0; j < CW; j++) begin
      for (int k = 0; k < NC; k++) begin
        bl.data[k] = w[k*CW + j];
        bm.data[k] = w[k*CW + CW - 1 - j];
      end
      bl.done = (j == CW - 1);
      bm.done = bl.done;
      q_l.push_back(bl);
      q_m.push_back(bm);
    end
  endfunction

  // One clock of stimulus, entered and left just after a falling edge.
  // rem = enabled shift cycles still owed to the word in flight.
  task automatic cycle(input logic v, input logic [PW-1:0] w, input logic se);
    logic exp_ready;
    pv  = v;
    pin = w;
    sen = se;
    #1;
    exp_ready = (rem == 0) || (rem == 1 && se);
    check("ready_lsb", 64'(bus_l.pixel_ready), 64'(exp_ready));
    check("ready_msb", 64'(bus_m.pixel_ready), 64'(exp_ready));
    check("busy_lsb",  64'(bus_l.busy), 64'(rem != 0));
    check("busy_msb",  64'(bus_m.busy), 64'(rem != 0));
    @(posedge sclk);
    if (rem != 0 && se) rem--;
    if (v && exp_ready) begin
      rem = CW;
      push_word(w);
    end
    @(negedge sclk);
  endtask

  task automatic idle_cycles(input int n, input logic se);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, se);
  endtask

  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid_lsb", 64'(bus_l.sdata_valid), 64'(0));
    check("rst_data_lsb",  64'(bus_l.sdata_out),   64'(0));
    check("rst_done_lsb",  64'(bus_l.word_done),   64'(0));
    check("rst_busy_lsb",  64'(bus_l.busy),        64'(0));
    check("rst_valid_msb", 64'(bus_m.sdata_valid), 64'(0));
    check("rst_data_msb",  64'(bus_m.sdata_out),   64'(0));
    check("rst_done_msb",  64'(bus_m.word_done),   64'(0));
    q_l.delete();
    q_m.delete();
    rem    = 0;
    last_l = '0;
    last_m = '0;
    @(negedge sclk);
    pv    = 1'b0;
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expected beat per valid output; between beats the
  // lanes must hold their last bit and word_done must stay low.
  always @(posedge sclk) begin
    #1;
    if (rst_n && mon_en) begin
      if (bus_l.sdata_valid) begin
        valid_cnt++;
        check("lsb_beat_expected", 64'(q_l.size() != 0), 64'(1));
        if (q_l.size() != 0) begin
          e_l = q_l.pop_front();
          check("lsb_data", 64'(bus_l.sdata_out), 64'(e_l.data));
          check("lsb_word_done", 64'(bus_l.word_done), 64'(e_l.done));
          last_l = e_l.data;
        end
      end else begin
        check("lsb_done_no_beat", 64'(bus_l.word_done), 64'(0));
        check("lsb_hold", 64'(bus_l.sdata_out), 64'(last_l));
      end
      if (bus_m.sdata_valid) begin
        check("msb_beat_expected", 64'(q_m.size() != 0), 64'(1));
        if (q_m.size() != 0) begin
          e_m = q_m.pop_front();
          check("msb_data", 64'(bus_m.sdata_out), 64'(e_m.data));
          check("msb_word_done", 64'(bus_m.word_done), 64'(e_m.done));
          last_m = e_m.data;
        end
      end else begin
        check("msb_done_no_beat", 64'(bus_m.word_done), 64'(0));
        check("msb_hold", 64'(bus_m.sdata_out), 64'(last_m));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    pv        = 1'b0;
    pin       = '0;
    sen       = 1'b0;
    rem       = 0;
    valid_cnt = 0;
    last_l    = '0;
    last_m    = '0;
    mon_en    = 1'b0;
    repeat (2) @(negedge sclk);

    // Reset state, observed just before release and after it.
    check("init_valid", 64'(bus_l.sdata_valid), 64'(0));
    check("init_data",  64'(bus_l.sdata_out),   64'(0));
    rst_n = 1'b1;
    #1;
    check("idle_done",  64'(bus_l.word_done),   64'(0));
    check("idle_busy",  64'(bus_l.busy),        64'(0));
    check("idle_ready", 64'(bus_l.pixel_ready), 64'(1));
    check("idle_data_msb", 64'(bus_m.sdata_out), 64'(0));
    mon_en = 1'b1;
    @(negedge sclk);

    // One set bit at the start of each chain.
    cycle(1'b1, (42'd1 << 0) | (42'd1 << 21), 1'b1);
    valid_cnt = 0;
    idle_cycles(CW + 1, 1'b1);
    check("single_word_beats", 64'(valid_cnt), 64'(CW));

    // One set bit at the top of each chain, then bit 19 of chain 0.
    cycle(1'b1, (42'd1 << 20) | (42'd1 << 41), 1'b1);
    idle_cycles(CW + 1, 1'b1);
    cycle(1'b1, 42'd1 << 19, 1'b1);
    idle_cycles(CW + 1, 1'b1);

    // Three-cycle stall after beat 5.
    r = {$urandom(), $urandom()};
    cycle(1'b1, r[PW-1:0], 1'b1);
    valid_cnt = 0;
    idle_cycles(5, 1'b1);
    idle_cycles(3, 1'b0);
    idle_cycles(CW - 5 + 1, 1'b1);
    check("stall_word_beats", 64'(valid_cnt), 64'(CW));

    // Back-to-back words with pixel_valid held high until the second lands.
    cycle(1'b1, 42'h2AA_AAAA_AAAA, 1'b1);
    valid_cnt = 0;
    for (int i = 0; i < CW; i++) cycle(1'b1, 42'h155_5555_5555, 1'b1);
    idle_cycles(CW + 1, 1'b1);
    check("b2b_contiguous_beats", 64'(valid_cnt), 64'(2 * CW));

    // Reset mid-word at beat 10, then a clean word.
    r = {$urandom(), $urandom()};
    cycle(1'b1, r[PW-1:0], 1'b1);
    idle_cycles(10, 1'b1);
    pulse_reset();
    r = {$urandom(), $urandom()};
    cycle(1'b1, r[PW-1:0], 1'b1);
    valid_cnt = 0;
    idle_cycles(CW + 1, 1'b1);
    check("post_reset_beats", 64'(valid_cnt), 64'(CW));

    // Random traffic with random stalls.
    for (int i = 0; i < 800; i++) begin
      r = {$urandom(), $urandom()};
      cycle($urandom_range(0, 3) != 0, r[PW-1:0], $urandom_range(0, 4) != 0);
    end

    // Drain, bounded.
    for (int i = 0; i < 200 && (rem != 0 || q_l.size() != 0 || q_m.size() != 0); i++)
      cycle(1'b0, '0, 1'b1);
    check("drain_lsb", 64'(q_l.size()), 64'(0));
    check("drain_msb", 64'(q_m.size()), 64'(0));
    check("drain_busy", 64'(bus_l.busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
